fpdiv_seq: RTL and testbench
============================

FPDIV_SEQ -- requirements
Module: fpdiv_seq

Interface
REQ-001 Parameter DEPTH, default 4, operand FIFO entries (power of two).
REQ-002 Parameter LAUNCH_CYC, default 2, cycles DIV_RST is held high per launch.
REQ-003 Parameter TIMEOUT_CYC, default 255, max RUN cycles before abort.
REQ-004 CLOCK  in  1  sole clock; all logic on rising edge.
REQ-005 RESET  in  1  synchronous, active-low reset.
REQ-006 IN_VALID  in  1  operand pair offered.
REQ-007 IN_READY  out  1  operand FIFO can accept.
REQ-008 IN_A / IN_B  in  32  IEEE-754 single dividend / divisor.
REQ-009 DIV_A / DIV_B  out  32  registered operands to fpdiv InputA / InputB.
REQ-010 DIV_RST  out  1  drives fpdiv RESET (active-high start/park).
REQ-011 DIV_DONE  in  1  fpdiv DONE.
REQ-012 DIV_RESULT  in  32  fpdiv AbyB.
REQ-013 DIV_EXC  in  2  fpdiv EXCEPTION.
REQ-014 OUT_VALID  out  1  result held.
REQ-015 OUT_READY  in  1  consumer accepts result.
REQ-016 OUT_RESULT  out  32  quotient.
REQ-017 OUT_EXC  out  2  captured exception code.
REQ-018 OUT_TIMEOUT  out  1  divider failed to finish.
REQ-019 OUT_TAG  out  2  launch sequence number modulo 4.

Function
REQ-020 The block SHALL push {IN_A,IN_B} on a cycle with IN_VALID & IN_READY; IN_READY = FIFO not full, registered-count based, with no bypass when empty.
REQ-021 States SHALL be IDLE, LAUNCH, RUN, HOLD.
- IDLE: FIFO non-empty -> pop into DIV_A/DIV_B, clear counter, go LAUNCH.
- LAUNCH: DIV_RST=1 for LAUNCH_CYC cycles -> RUN.
- RUN: DIV_RST=0; counter increments each cycle; DIV_DONE ignored in first RUN cycle (guard); DIV_DONE=1 thereafter -> capture DIV_RESULT/DIV_EXC, OUT_TIMEOUT=0, go HOLD; counter==TIMEOUT_CYC without DONE -> OUT_RESULT=32'h7FC00000, OUT_EXC=2'b00, OUT_TIMEOUT=1, go HOLD.
- HOLD: OUT_VALID=1, DIV_RST=1; OUT_READY=1 -> OUT_VALID=0, OUT_TAG increments (wraps 3->0), go IDLE.
REQ-022 DIV_A/DIV_B SHALL stay stable from LAUNCH entry until next pop; DIV_RST SHALL be 1 in IDLE, LAUNCH, HOLD.
REQ-023 OUT_RESULT/OUT_EXC/OUT_TIMEOUT/OUT_TAG SHALL stay stable while OUT_VALID=1.
REQ-024 Minimum latency, FIFO empty, divider DONE N cycles after DIV_RST falls (N>=2): OUT_VALID rises 1 (push) + 1 (IDLE) + LAUNCH_CYC + N cycles after IN accept.
REQ-025 Push SHALL be allowed in every state, including same cycle as pop; full FIFO with pop the same cycle still refuses the push (IN_READY reflects pre-pop count).
REQ-026 Results SHALL leave in FIFO (arrival) order; only one division in flight.

Reset
REQ-027 RESET=0 at any edge, including mid-RUN or HOLD, SHALL flush FIFO, enter IDLE, and set IN_READY=0 during reset, DIV_RST=1, DIV_A=DIV_B=0, OUT_VALID=0, OUT_RESULT=0, OUT_EXC=0, OUT_TIMEOUT=0, OUT_TAG=0; IN_READY=1 first cycle after release.

Structure
REQ-028 Shared package fpdiv_pkg SHALL hold the state enum, QNAN constant 32'h7FC00000, and default parameter values.
REQ-029 Operand storage SHALL be sub-module fpdiv_opfifo (synchronous FIFO, width 64, DEPTH entries, full/empty/count); FSM and counter in fpdiv_seq.

Verification
REQ-030 Bench SHALL use fpdiv or a stub with programmable DONE latency.
REQ-031 4.0/2.0 (40800000/40000000), DONE 5 cycles after release -> OUT_RESULT=40000000, OUT_EXC=00, OUT_TAG=0, latency per REQ-024.
REQ-032 Five pairs pushed back-to-back with OUT_READY=0 -> IN_READY low after 4 (then 5th once first popped), results drain in order, tags 0,1,2,3,0.
REQ-033 Stub never asserts DONE -> after 255 RUN cycles OUT_RESULT=7FC00000, OUT_TIMEOUT=1; next pair proceeds normally.
REQ-034 4.0/0.0 with stub returning EXCEPTION=2'b01 -> OUT_EXC=01 passed through unchanged, OUT_TIMEOUT=0.
REQ-035 RESET=0 during RUN with 2 entries queued -> next cycle IDLE, FIFO empty, OUT_VALID=0, DIV_RST=1; no stale result appears after release.
REQ-036 DIV_DONE stuck high from stub -> not sampled in first RUN cycle; capture occurs on second RUN cycle.

Source files
------------

// File: rtl/fpdiv_pkg.sv
// Shared types and constants for the sequential fpdiv wrapper.
// Holds the controller state enum, the operand-pair payload, the quiet-NaN
// value reported on a divider timeout, and the default parameter values.
package fpdiv_pkg;

  localparam int unsigned DEPTH_DEF       = 4;
  localparam int unsigned LAUNCH_CYC_DEF  = 2;
  localparam int unsigned TIMEOUT_CYC_DEF = 255;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  // Dividend in the upper word, divisor in the lower word.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } op_pair_t;

  localparam int unsigned OP_W = $bits(op_pair_t);

endpackage

// File: rtl/fpdiv_opfifo.sv
// Synchronous operand FIFO (DEPTH entries, power of two).
// Ports: clk, rst_n (sync active-low flush), push/wdata write side,
// pop/rdata read side (rdata shows the head entry), full/empty/count status
// derived from the registered occupancy count.
module fpdiv_opfifo
  import fpdiv_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned WIDTH = OP_W,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fpdiv_seq.sv
// Sequencer around an iterative fpdiv core.
// Queues operand pairs (IN_*), launches one division at a time by pulsing
// DIV_RST for LAUNCH_CYC cycles, waits for DIV_DONE (with a TIMEOUT_CYC
// abort that reports a quiet NaN), and holds the result on OUT_* until
// OUT_READY. OUT_TAG numbers results modulo 4 in arrival order.
// CLOCK: rising-edge clock. RESET: synchronous active-low reset.
module fpdiv_seq
  import fpdiv_pkg::*;
#(
  parameter int unsigned DEPTH       = DEPTH_DEF,
  parameter int unsigned LAUNCH_CYC  = LAUNCH_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] IN_A,
  input  logic [31:0] IN_B,
  output logic [31:0] DIV_A,
  output logic [31:0] DIV_B,
  output logic        DIV_RST,
  input  logic        DIV_DONE,
  input  logic [31:0] DIV_RESULT,
  input  logic [1:0]  DIV_EXC,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT_RESULT,
  output logic [1:0]  OUT_EXC,
  output logic        OUT_TIMEOUT,
  output logic [1:0]  OUT_TAG
);

  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned CNT_MAX = (TIMEOUT_CYC > LAUNCH_CYC) ? TIMEOUT_CYC : LAUNCH_CYC;
  localparam int unsigned TW    = $clog2(CNT_MAX + 1);

  state_e      state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [31:0] div_a_q, div_a_d;
  logic [31:0] div_b_q, div_b_d;
  logic        div_rst_q, div_rst_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_result_q, out_result_d;
  logic [1:0]  out_exc_q, out_exc_d;
  logic        out_timeout_q, out_timeout_d;
  logic [1:0]  out_tag_q, out_tag_d;
  logic        live_q;

  op_pair_t      fifo_wdata, fifo_rdata;
  logic          fifo_push_c, fifo_pop_c;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  // Ready follows the registered occupancy only, so a same-cycle pop never
  // frees a slot early; live_q keeps it low while reset is applied.
  assign IN_READY    = live_q && (fifo_count != CW'(DEPTH));
  assign fifo_push_c = IN_VALID && IN_READY && !fifo_full;
  assign fifo_wdata  = {IN_A, IN_B};

  fpdiv_opfifo #(
    .DEPTH (DEPTH),
    .WIDTH (OP_W)
  ) u_opfifo (
    .clk   (CLOCK),
    .rst_n (RESET),
    .push  (fifo_push_c),
    .wdata (fifo_wdata),
    .pop   (fifo_pop_c),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Controller next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    div_a_d       = div_a_q;
    div_b_d       = div_b_q;
    out_result_d  = out_result_q;
    out_exc_d     = out_exc_q;
    out_timeout_d = out_timeout_q;
    out_tag_d     = out_tag_q;
    fifo_pop_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop_c = 1'b1;
          div_a_d    = fifo_rdata.a;
          div_b_d    = fifo_rdata.b;
          cnt_d      = '0;
          state_d    = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (cnt_q == TW'(LAUNCH_CYC - 1)) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + TW'(1);
        // DONE may still be high from the previous operation in the first
        // RUN cycle, so it only counts once cnt_q has moved off zero.
        if (DIV_DONE && (cnt_q != '0)) begin
          out_result_d  = DIV_RESULT;
          out_exc_d     = DIV_EXC;
          out_timeout_d = 1'b0;
          state_d       = ST_HOLD;
        end else if (cnt_q == TW'(TIMEOUT_CYC - 1)) begin
          out_result_d  = QNAN;
          out_exc_d     = 2'b00;
          out_timeout_d = 1'b1;
          state_d       = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (OUT_READY) begin
          out_tag_d = out_tag_q + 2'd1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    div_rst_d   = (state_d != ST_RUN);
    out_valid_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      div_a_q       <= '0;
      div_b_q       <= '0;
      div_rst_q     <= 1'b1;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_exc_q     <= '0;
      out_timeout_q <= 1'b0;
      out_tag_q     <= '0;
      live_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      div_a_q       <= div_a_d;
      div_b_q       <= div_b_d;
      div_rst_q     <= div_rst_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_exc_q     <= out_exc_d;
      out_timeout_q <= out_timeout_d;
      out_tag_q     <= out_tag_d;
      live_q        <= 1'b1;
    end
  end

  assign DIV_A       = div_a_q;
  assign DIV_B       = div_b_q;
  assign DIV_RST     = div_rst_q;
  assign OUT_VALID   = out_valid_q;
  assign OUT_RESULT  = out_result_q;
  assign OUT_EXC     = out_exc_q;
  assign OUT_TIMEOUT = out_timeout_q;
  assign OUT_TAG     = out_tag_q;

endmodule

// File: tb/tb_fpdiv_seq.sv
// Directed bench for fpdiv_seq with a divider stub of programmable DONE
// latency (DONE rises N cycles after DIV_RST falls), stuck-high and
// never-done modes, and a table of hand-computed quotients.
`timescale 1ns/1ps
module tb_fpdiv_seq;

  localparam int MODE_LAT   = 0;
  localparam int MODE_STUCK = 1;
  localparam int MODE_NEVER = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic [31:0] div_a, div_b;
  logic        div_rst, div_done;
  logic [31:0] div_result;
  logic [1:0]  div_exc;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [1:0]  out_exc;
  logic        out_timeout;
  logic [1:0]  out_tag;

  int checks = 0;
  int errors = 0;

  int stub_mode = MODE_LAT;
  int stub_lat  = 5;
  int run_cnt   = 0;
  logic [1:0] stub_exc = 2'b00;

  always #5 clk = ~clk;

  fpdiv_seq dut (
    .CLOCK       (clk),
    .RESET       (rst_n),
    .IN_VALID    (in_valid),
    .IN_READY    (in_ready),
    .IN_A        (in_a),
    .IN_B        (in_b),
    .DIV_A       (div_a),
    .DIV_B       (div_b),
    .DIV_RST     (div_rst),
    .DIV_DONE    (div_done),
    .DIV_RESULT  (div_result),
    .DIV_EXC     (div_exc),
    .OUT_VALID   (out_valid),
    .OUT_READY   (out_ready),
    .OUT_RESULT  (out_result),
    .OUT_EXC     (out_exc),
    .OUT_TIMEOUT (out_timeout),
    .OUT_TAG     (out_tag)
  );

  // Divider stub: cycles spent out of reset, and a quotient lookup table.
  always @(posedge clk) begin
    if (div_rst) run_cnt <= 0;
    else         run_cnt <= run_cnt + 1;
  end

  always_comb begin
    case (stub_mode)
      MODE_STUCK: div_done = 1'b1;
      MODE_NEVER: div_done = 1'b0;
      default:    div_done = !div_rst && (run_cnt >= stub_lat);
    endcase
  end

  function automatic logic [31:0] stub_quot(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40800000, 32'h40000000}: return 32'h40000000; // 4/2
      {32'h40C00000, 32'h40000000}: return 32'h40400000; // 6/2
      {32'h3F800000, 32'h40000000}: return 32'h3F000000; // 1/2
      {32'h40C00000, 32'h40800000}: return 32'h3FC00000; // 6/4
      {32'h3F800000, 32'h40800000}: return 32'h3E800000; // 1/4
      {32'h40800000, 32'h00000000}: return 32'h7F800000; // 4/0
      default:                      return 32'hDEADBEEF;
    endcase
  endfunction

  assign div_result = stub_quot(div_a, div_b);
  assign div_exc    = stub_exc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    chk("push_ready", 32'(in_ready), 32'd1);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!out_valid && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("valid_drop", 32'(out_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  logic [31:0] pa [5];
  logic [31:0] pb [5];
  logic [31:0] pq [5];

  initial begin
    int n;
    logic stale;
    pa[0] = 32'h40800000; pb[0] = 32'h40000000; pq[0] = 32'h40000000;
    pa[1] = 32'h40C00000; pb[1] = 32'h40000000; pq[1] = 32'h40400000;
    pa[2] = 32'h3F800000; pb[2] = 32'h40000000; pq[2] = 32'h3F000000;
    pa[3] = 32'h40C00000; pb[3] = 32'h40800000; pq[3] = 32'h3FC00000;
    pa[4] = 32'h3F800000; pb[4] = 32'h40800000; pq[4] = 32'h3E800000;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    step(); step(); step();
    chk("rst_in_ready",   32'(in_ready),    32'd0);
    chk("rst_div_rst",    32'(div_rst),     32'd1);
    chk("rst_div_a",      div_a,            32'd0);
    chk("rst_div_b",      div_b,            32'd0);
    chk("rst_out_valid",  32'(out_valid),   32'd0);
    chk("rst_out_result", out_result,       32'd0);
    chk("rst_out_exc",    32'(out_exc),     32'd0);
    chk("rst_timeout",    32'(out_timeout), 32'd0);
    chk("rst_tag",        32'(out_tag),     32'd0);
    rst_n = 1'b1;
    step();
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // 4.0 / 2.0 with DONE 5 cycles after release: 1+1+2+5 = 9 cycles.
    stub_mode = MODE_LAT; stub_lat = 5;
    push(32'h40800000, 32'h40000000);
    step();
    chk("launch_div_a",   div_a,          32'h40800000);
    chk("launch_div_b",   div_b,          32'h40000000);
    chk("launch_div_rst", 32'(div_rst),   32'd1);
    step(); step();
    chk("run_div_rst", 32'(div_rst), 32'd0);
    wait_valid(50, n);
    chk("lat_basic",   32'(n + 3),        32'd9);
    chk("res_basic",   out_result,        32'h40000000);
    chk("exc_basic",   32'(out_exc),      32'd0);
    chk("tag_basic",   32'(out_tag),      32'd0);
    chk("to_basic",    32'(out_timeout),  32'd0);
    chk("hold_div_rst", 32'(div_rst),     32'd1);
    handshake();
    chk("tag_incr", 32'(out_tag), 32'd1);

    // Five back-to-back pairs; consumer stalled, then drained in order.
    do_reset();
    stub_lat = 3;
    for (int i = 0; i < 5; i++) push(pa[i], pb[i]);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      wait_valid(50, n);
      chk("drain_valid",  32'(out_valid),   32'd1);
      chk("drain_result", out_result,       pq[k]);
      chk("drain_tag",    32'(out_tag),     32'(k % 4));
      chk("drain_to",     32'(out_timeout), 32'd0);
      handshake();
      if (k == 0) begin
        chk("full_pop_refuse", 32'(in_ready), 32'd0);
        step();
        chk("after_pop_ready", 32'(in_ready), 32'd1);
      end
    end

    // Divider never finishes: abort after 255 RUN cycles (3 + 255 = 258).
    do_reset();
    stub_mode = MODE_NEVER; stub_exc = 2'b11;
    push(32'h40800000, 32'h40000000);
    wait_valid(400, n);
    chk("lat_timeout", 32'(n),           32'd258);
    chk("res_timeout", out_result,       32'h7FC00000);
    chk("exc_timeout", 32'(out_exc),     32'd0);
    chk("to_timeout",  32'(out_timeout), 32'd1);
    chk("tag_timeout", 32'(out_tag),     32'd0);
    handshake();
    stub_mode = MODE_LAT; stub_lat = 4; stub_exc = 2'b00;
    push(32'h3F800000, 32'h40800000);
    wait_valid(50, n);
    chk("lat_post_to", 32'(n),           32'd8);
    chk("res_post_to", out_result,       32'h3E800000);
    chk("to_post_to",  32'(out_timeout), 32'd0);
    chk("tag_post_to", 32'(out_tag),     32'd1);
    handshake();

    // Divide by zero: exception code passes through, minimum latency N=2.
    stub_exc = 2'b01; stub_lat = 2;
    push(32'h40800000, 32'h00000000);
    wait_valid(50, n);
    chk("lat_dz", 32'(n),           32'd6);
    chk("res_dz", out_result,       32'h7F800000);
    chk("exc_dz", 32'(out_exc),     32'd1);
    chk("to_dz",  32'(out_timeout), 32'd0);
    chk("tag_dz", 32'(out_tag),     32'd2);
    handshake();
    stub_exc = 2'b00;

    // DONE stuck high: ignored in first RUN cycle, captured on the second.
    stub_mode = MODE_STUCK;
    push(32'h3F800000, 32'h40000000);
    wait_valid(50, n);
    chk("lat_stuck", 32'(n),       32'd5);
    chk("res_stuck", out_result,   32'h3F000000);
    chk("tag_stuck", 32'(out_tag), 32'd3);
    handshake();
    chk("tag_wrap", 32'(out_tag), 32'd0);
    stub_mode = MODE_LAT;

    // Reset mid-RUN with two entries queued; nothing stale afterwards.
    stub_lat = 50;
    push(pa[0], pb[0]);
    push(pa[1], pb[1]);
    push(pa[2], pb[2]);
    n = 0;
    while (div_rst && n < 20) begin
      step();
      n++;
    end
    chk("mid_run", 32'(div_rst), 32'd0);
    rst_n = 1'b0;
    step();
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_div_rst",   32'(div_rst),   32'd1);
    chk("mr_div_a",     div_a,          32'd0);
    chk("mr_in_ready",  32'(in_ready),  32'd0);
    chk("mr_tag",       32'(out_tag),   32'd0);
    rst_n = 1'b1;
    step();
    chk("mr_rel_ready", 32'(in_ready), 32'd1);
    stub_lat = 3;
    stale = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (out_valid || !div_rst) stale = 1'b1;
      step();
    end
    chk("mr_no_stale", 32'(stale), 32'd0);
    push(32'h40800000, 32'h40000000);
    wait_valid(50, n);
    chk("lat_after_mr", 32'(n),       32'd7);
    chk("res_after_mr", out_result,   32'h40000000);
    chk("tag_after_mr", 32'(out_tag), 32'd0);
    handshake();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
